// File: rtl/axi_slave_responder_pkg.sv
// rtl/axi_slave_responder_pkg.sv - shared AXI channel types, response codes and FSM encodings
package axi_slave_responder_pkg;

    localparam int AXI_DATA_W     = 32;
    localparam int AXI_ADDR_W     = 16;
    localparam int AXI_ID_W_W     = 5;
    localparam int AXI_ID_R_W     = 5;
    localparam int AXI_FIFO_DEPTH = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [AXI_ID_W_W-1:0]   awid;
        logic [AXI_ADDR_W-1:0]   awaddr;
        logic [7:0]              awlen;
        logic                    awvalid;
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic                    wlast;
        logic                    wvalid;
        logic [AXI_ID_R_W-1:0]   arid;
        logic [AXI_ADDR_W-1:0]   araddr;
        logic [7:0]              arlen;
        logic                    arvalid;
        logic                    bready;
        logic                    rready;
    } axi_mosi_t;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic                  arready;
        logic [AXI_ID_W_W-1:0] bid;
        logic [1:0]            bresp;
        logic                  bvalid;
        logic [AXI_ID_R_W-1:0] rid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
        logic                  rvalid;
    } axi_miso_t;

    typedef enum logic [0:0] {W_IDLE, W_DATA} w_state_e;
    typedef enum logic [1:0] {B_IDLE, B_DELAY, B_SEND} b_state_e;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_DATA} r_state_e;

    // A burst is clean only if WLAST was never seen early and is present on the final beat
    function automatic logic [1:0] write_resp(input logic early_last, input logic final_last);
        return (early_last || !final_last) ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready FIFO with registered occupancy and combinational head read
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      cnt_q;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign ready_o = (cnt_q != (PW+1)'(DEPTH));
    assign valid_o = (cnt_q != '0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axi_slave_responder.sv
// rtl/axi_slave_responder.sv - memoryless AXI4 subordinate answering B/R after a programmable delay
module axi_slave_responder
    import axi_slave_responder_pkg::*;
#(
    parameter int DATA_WIDTH = AXI_DATA_W,
    parameter int ADDR_WIDTH = AXI_ADDR_W,
    parameter int ID_W_WIDTH = AXI_ID_W_W,
    parameter int ID_R_WIDTH = AXI_ID_R_W,
    parameter int FIFO_DEPTH = AXI_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic [7:0]  resp_delay_i,
    input  axi_mosi_t   s_axi_i,
    output axi_miso_t   s_axi_o,
    output logic [15:0] wr_count_o,
    output logic [15:0] rd_count_o,
    output logic        idle_o
);
    localparam int AW_Q_W = ID_W_WIDTH + 8;
    localparam int B_Q_W  = ID_W_WIDTH + 2;
    localparam int AR_Q_W = ID_R_WIDTH + ADDR_WIDTH + 8;

    logic                  active_q;
    logic                  aw_q_ready, aw_q_valid, aw_pop;
    logic [AW_Q_W-1:0]     aw_q_head;
    logic                  b_q_ready, b_q_valid;
    logic [B_Q_W-1:0]      b_q_head, b_q_in;
    logic                  ar_q_ready, ar_q_valid, ar_pop;
    logic [AR_Q_W-1:0]     ar_q_head;

    w_state_e              w_state_q;
    logic                  wready_q;
    logic [7:0]            w_cnt_q;
    logic                  w_err_q;
    b_state_e              b_state_q;
    logic                  bvalid_q;
    logic [7:0]            b_dly_q;
    logic [15:0]           wr_count_q;
    r_state_e              r_state_q;
    logic                  rvalid_q;
    logic [7:0]            r_dly_q;
    logic [7:0]            r_cnt_q;
    logic [15:0]           rd_count_q;

    logic                  w_hs, w_final, b_hs, r_hs, r_final;
    logic [7:0]            aw_head_len, ar_head_len;
    logic [ID_W_WIDTH-1:0] aw_head_id, b_head_id;
    logic [1:0]            b_head_resp;
    logic [ID_R_WIDTH-1:0] ar_head_id;
    logic [ADDR_WIDTH-1:0] ar_head_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  unused_in;

    assign unused_in = ^{s_axi_i.awaddr, s_axi_i.wdata, s_axi_i.wstrb};

    // Address readies stay low while reset is held even though the queues report space
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) active_q <= 1'b0;
        else          active_q <= 1'b1;
    end

    stream_fifo #(.WIDTH(AW_Q_W), .DEPTH(FIFO_DEPTH)) u_aw_q (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .valid_i(s_axi_i.awvalid && active_q), .ready_o(aw_q_ready),
        .data_i({s_axi_i.awid, s_axi_i.awlen}),
        .valid_o(aw_q_valid), .ready_i(aw_pop), .data_o(aw_q_head)
    );

    stream_fifo #(.WIDTH(B_Q_W), .DEPTH(FIFO_DEPTH)) u_b_q (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .valid_i(aw_pop), .ready_o(b_q_ready), .data_i(b_q_in),
        .valid_o(b_q_valid), .ready_i(b_hs), .data_o(b_q_head)
    );

    stream_fifo #(.WIDTH(AR_Q_W), .DEPTH(FIFO_DEPTH)) u_ar_q (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .valid_i(s_axi_i.arvalid && active_q), .ready_o(ar_q_ready),
        .data_i({s_axi_i.arid, s_axi_i.araddr, s_axi_i.arlen}),
        .valid_o(ar_q_valid), .ready_i(ar_pop), .data_o(ar_q_head)
    );

    assign aw_head_id   = aw_q_head[AW_Q_W-1:8];
    assign aw_head_len  = aw_q_head[7:0];
    assign b_head_id    = b_q_head[B_Q_W-1:2];
    assign b_head_resp  = b_q_head[1:0];
    assign ar_head_id   = ar_q_head[AR_Q_W-1:ADDR_WIDTH+8];
    assign ar_head_addr = ar_q_head[ADDR_WIDTH+7:8];
    assign ar_head_len  = ar_q_head[7:0];

    assign w_hs    = wready_q && s_axi_i.wvalid;
    assign w_final = (w_cnt_q == aw_head_len);
    assign aw_pop  = w_hs && w_final;
    assign b_q_in  = {aw_head_id, write_resp(w_err_q, s_axi_i.wlast)};
    assign b_hs    = bvalid_q && s_axi_i.bready;
    assign r_hs    = rvalid_q && s_axi_i.rready;
    assign r_final = (r_cnt_q == ar_head_len);
    assign ar_pop  = r_hs && r_final;
    assign r_data  = DATA_WIDTH'(32'h30) + DATA_WIDTH'(ar_head_addr >> 2) + DATA_WIDTH'(r_cnt_q);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            w_state_q <= W_IDLE;
            wready_q  <= 1'b0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: if (aw_q_valid && b_q_ready) begin
                    w_state_q <= W_DATA;
                    wready_q  <= 1'b1;
                end
                W_DATA: if (w_hs) begin
                    if (w_final) begin
                        w_state_q <= W_IDLE;
                        wready_q  <= 1'b0;
                        w_cnt_q   <= '0;
                        w_err_q   <= 1'b0;
                    end else begin
                        w_cnt_q <= w_cnt_q + 8'd1;
                        w_err_q <= w_err_q | s_axi_i.wlast;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            b_state_q  <= B_IDLE;
            bvalid_q   <= 1'b0;
            b_dly_q    <= '0;
            wr_count_q <= '0;
        end else begin
            case (b_state_q)
                B_IDLE: if (b_q_valid) begin
                    if (resp_delay_i == 8'd0) begin
                        b_state_q <= B_SEND;
                        bvalid_q  <= 1'b1;
                    end else begin
                        b_state_q <= B_DELAY;
                        b_dly_q   <= resp_delay_i;
                    end
                end
                B_DELAY: if (b_dly_q <= 8'd1) begin
                    b_state_q <= B_SEND;
                    bvalid_q  <= 1'b1;
                end else begin
                    b_dly_q <= b_dly_q - 8'd1;
                end
                B_SEND: if (s_axi_i.bready) begin
                    b_state_q  <= B_IDLE;
                    bvalid_q   <= 1'b0;
                    wr_count_q <= wr_count_q + 16'd1;
                end
                default: b_state_q <= B_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state_q  <= R_IDLE;
            rvalid_q   <= 1'b0;
            r_dly_q    <= '0;
            r_cnt_q    <= '0;
            rd_count_q <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (ar_q_valid) begin
                    if (resp_delay_i == 8'd0) begin
                        r_state_q <= R_DATA;
                        rvalid_q  <= 1'b1;
                    end else begin
                        r_state_q <= R_DELAY;
                        r_dly_q   <= resp_delay_i;
                    end
                end
                R_DELAY: if (r_dly_q <= 8'd1) begin
                    r_state_q <= R_DATA;
                    rvalid_q  <= 1'b1;
                end else begin
                    r_dly_q <= r_dly_q - 8'd1;
                end
                R_DATA: if (r_hs) begin
                    if (r_final) begin
                        r_state_q  <= R_IDLE;
                        rvalid_q   <= 1'b0;
                        r_cnt_q    <= '0;
                        rd_count_q <= rd_count_q + 16'd1;
                    end else begin
                        r_cnt_q <= r_cnt_q + 8'd1;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Response payload fields read as zero whenever their valid is low
    always_comb begin
        s_axi_o         = '0;
        s_axi_o.awready = aw_q_ready && active_q;
        s_axi_o.wready  = wready_q;
        s_axi_o.arready = ar_q_ready && active_q;
        s_axi_o.bvalid  = bvalid_q;
        s_axi_o.rvalid  = rvalid_q;
        if (bvalid_q) begin
            s_axi_o.bid   = b_head_id;
            s_axi_o.bresp = b_head_resp;
        end
        if (rvalid_q) begin
            s_axi_o.rid   = ar_head_id;
            s_axi_o.rdata = r_data;
            s_axi_o.rresp = RESP_OKAY;
            s_axi_o.rlast = r_final;
        end
    end

    assign wr_count_o = wr_count_q;
    assign rd_count_o = rd_count_q;
    assign idle_o     = !aw_q_valid && !b_q_valid && !ar_q_valid &&
                        (w_state_q == W_IDLE) && (b_state_q == B_IDLE) && (r_state_q == R_IDLE);

endmodule

// File: tb/tb_axi_slave_responder.sv
// tb/tb_axi_slave_responder.sv - randomized bench for axi_slave_responder against a queue-based response model
module tb_axi_slave_responder;
    import axi_slave_responder_pkg::*;

    logic        clk = 1'b0;
    logic        arstn;
    logic [7:0]  resp_delay;
    axi_mosi_t   mosi;
    axi_miso_t   miso;
    logic [15:0] wr_count, rd_count;
    logic        idle;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct { logic [AXI_ID_W_W-1:0] id; logic [7:0] len; } aw_t;
    typedef struct { logic [AXI_ID_W_W-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [AXI_ID_R_W-1:0] id; logic [31:0] data; logic last; } r_exp_t;

    aw_t    aw_pend[$];
    b_exp_t exp_b[$];
    r_exp_t exp_r[$];
    b_exp_t eb;
    r_exp_t er;
    int wr_m = 0, rd_m = 0;
    int t_whs = 0, t_bvalid = 0, t_arhs = 0, t_rvalid = 0, t_awready = 0;
    int b_mode = 0, r_mode = 0;
    logic w_gaps = 1'b0;
    logic pb_v = 0, pb_r = 0, pr_v = 0, pr_r = 0, paw = 0;
    logic [63:0] pb_pl = '0, pr_pl = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_slave_responder dut (
        .clk_i(clk), .arstn_i(arstn), .resp_delay_i(resp_delay),
        .s_axi_i(mosi), .s_axi_o(miso),
        .wr_count_o(wr_count), .rd_count_o(rd_count), .idle_o(idle)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (b_mode)
                0:       mosi.bready = 1'b1;
                1:       mosi.bready = 1'($urandom_range(0, 1));
                default: mosi.bready = ~mosi.bready;
            endcase
            case (r_mode)
                0:       mosi.rready = 1'b1;
                1:       mosi.rready = 1'($urandom_range(0, 1));
                default: mosi.rready = ~mosi.rready;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!arstn) begin
            pb_v = 0; pr_v = 0; paw = 0;
        end else begin
            if (pb_v && !pb_r) begin
                check_eq("b_hold_valid", 64'(miso.bvalid), 64'd1);
                check_eq("b_hold_payload", 64'({miso.bid, miso.bresp}), pb_pl);
            end
            if (pr_v && !pr_r) begin
                check_eq("r_hold_valid", 64'(miso.rvalid), 64'd1);
                check_eq("r_hold_payload", 64'({miso.rid, miso.rdata, miso.rlast}), pr_pl);
            end
            if (miso.bvalid && !pb_v) t_bvalid = cyc;
            if (miso.rvalid && !pr_v) t_rvalid = cyc;
            if (miso.awready && !paw) t_awready = cyc;
            if (mosi.wvalid && miso.wready) t_whs = cyc;
            if (mosi.arvalid && miso.arready) t_arhs = cyc;
            if (miso.bvalid && mosi.bready) begin
                check_eq("b_expected_pending", 64'(exp_b.size() > 0), 64'd1);
                if (exp_b.size() > 0) begin
                    eb = exp_b.pop_front();
                    check_eq("bid", 64'(miso.bid), 64'(eb.id));
                    check_eq("bresp", 64'(miso.bresp), 64'(eb.resp));
                    wr_m++;
                end
            end
            if (miso.rvalid && mosi.rready) begin
                check_eq("r_expected_pending", 64'(exp_r.size() > 0), 64'd1);
                if (exp_r.size() > 0) begin
                    er = exp_r.pop_front();
                    check_eq("rid", 64'(miso.rid), 64'(er.id));
                    check_eq("rdata", 64'(miso.rdata), 64'(er.data));
                    check_eq("rlast", 64'(miso.rlast), 64'(er.last));
                    check_eq("rresp", 64'(miso.rresp), 64'd0);
                    if (er.last) rd_m++;
                end
            end
            pb_v = miso.bvalid; pb_r = mosi.bready; pb_pl = 64'({miso.bid, miso.bresp});
            pr_v = miso.rvalid; pr_r = mosi.rready; pr_pl = 64'({miso.rid, miso.rdata, miso.rlast});
            paw  = miso.awready;
        end
    end

    task automatic wait_ready(input int ch, input string tag);
        int n = 0;
        logic hs;
        forever begin
            @(negedge clk);
            hs = (ch == 0) ? miso.awready : ((ch == 1) ? miso.wready : miso.arready);
            @(posedge clk); #1;
            if (hs) break;
            n++;
            if (n > 500) begin
                check_eq({tag, "_ready_timeout"}, 64'(hs), 64'd1);
                break;
            end
        end
    endtask

    task automatic send_aw(input logic [AXI_ID_W_W-1:0] id, input logic [7:0] len);
        aw_t a;
        mosi.awvalid = 1'b1; mosi.awid = id; mosi.awlen = len; mosi.awaddr = 16'($urandom);
        wait_ready(0, "aw");
        mosi.awvalid = 1'b0;
        a.id = id; a.len = len;
        aw_pend.push_back(a);
    endtask

    // WLAST is driven only on beat lb (-1: never); the burst is OKAY only when lb is the final beat
    task automatic send_w(input int lb);
        aw_t a;
        b_exp_t e;
        check_eq("w_has_aw", 64'(aw_pend.size() > 0), 64'd1);
        if (aw_pend.size() == 0) return;
        a = aw_pend.pop_front();
        e.id = a.id;
        e.resp = (lb == int'(a.len)) ? 2'b00 : 2'b10;
        exp_b.push_back(e);
        for (int i = 0; i <= int'(a.len); i++) begin
            mosi.wvalid = 1'b0;
            if (w_gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            mosi.wvalid = 1'b1; mosi.wlast = (i == lb); mosi.wdata = $urandom; mosi.wstrb = '1;
            wait_ready(1, "w");
        end
        mosi.wvalid = 1'b0; mosi.wlast = 1'b0;
    endtask

    task automatic send_ar(input logic [AXI_ID_R_W-1:0] id, input logic [15:0] addr, input logic [7:0] len);
        r_exp_t e;
        mosi.arvalid = 1'b1; mosi.arid = id; mosi.araddr = addr; mosi.arlen = len;
        wait_ready(2, "ar");
        mosi.arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            e.id = id;
            e.data = 32'h30 + (32'(addr) / 4) + 32'(i);
            e.last = (i == int'(len));
            exp_r.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_b.size() + exp_r.size()) > 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_drained"}, 64'(exp_b.size() + exp_r.size()), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
        check_eq({tag, "_wr_count"}, 64'(wr_count), 64'(16'(wr_m)));
        check_eq({tag, "_rd_count"}, 64'(rd_count), 64'(16'(rd_m)));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int lb;
        logic stray;
        arstn = 1'b0; mosi = '0; resp_delay = 8'd0;
        repeat (2) @(posedge clk); #1;
        check_eq("rst_awready", 64'(miso.awready), 64'd0);
        check_eq("rst_arready", 64'(miso.arready), 64'd0);
        check_eq("rst_wready", 64'(miso.wready), 64'd0);
        check_eq("rst_valids", 64'({miso.bvalid, miso.rvalid}), 64'd0);
        check_eq("rst_idle", 64'(idle), 64'd1);
        check_eq("rst_counts", 64'({wr_count, rd_count}), 64'd0);
        arstn = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // 1: zero delay write, BVALID two cycles after the last W beat
        send_aw(5'd3, 8'd3);
        send_w(3);
        wait_drain("t1");
        check_eq("t1_b_latency", 64'(t_bvalid - t_whs), 64'd2);

        // 2: delayed read burst
        resp_delay = 8'd5;
        send_ar(5'd7, 16'h0008, 8'd2);
        wait_drain("t2");
        check_eq("t2_r_latency", 64'(t_rvalid - t_arhs), 64'd7);

        // 3: early WLAST still consumes AWLEN+1 beats and yields SLVERR
        resp_delay = 8'd2;
        send_aw(5'd9, 8'd3);
        send_w(1);
        check_eq("t3_wready_after", 64'(miso.wready), 64'd0);
        wait_drain("t3");

        // 4: AW queue backpressure
        resp_delay = 8'd0;
        for (int i = 0; i < 8; i++) send_aw(5'(i), 8'd1);
        check_eq("t4_aw_full", 64'(miso.awready), 64'd0);
        fork
            send_aw(5'd8, 8'd1);
            send_w(1);
        join
        check_eq("t4_awready_reassert", 64'(t_awready - t_whs), 64'd1);
        for (int i = 0; i < 8; i++) send_w(1);
        wait_drain("t4");

        // 5: RREADY toggling through a long burst
        r_mode = 2;
        resp_delay = 8'($urandom_range(0, 4));
        send_ar(5'd5, 16'($urandom), 8'd7);
        wait_drain("t5");

        // random concurrent traffic with random backpressure and delays
        b_mode = 1; r_mode = 1; w_gaps = 1'b1;
        fork
            for (int k = 0; k < 25; k++) begin
                aw_t a;
                resp_delay = 8'($urandom_range(0, 6));
                a.len = 8'($urandom_range(0, 7));
                send_aw(5'($urandom), a.len);
                lb = int'(a.len);
                if ($urandom_range(0, 3) == 0) begin
                    lb = $urandom_range(0, int'(a.len) + 1);
                    if (lb == int'(a.len) + 1) lb = -1;
                end
                send_w(lb);
            end
            for (int k = 0; k < 25; k++) begin
                send_ar(5'($urandom), 16'($urandom), 8'($urandom_range(0, 7)));
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
        join
        wait_drain("rand");
        check_eq("rand_idle", 64'(idle), 64'd1);

        // 6: reset in the middle of a read burst
        b_mode = 0; r_mode = 0; w_gaps = 1'b0; resp_delay = 8'd0;
        send_ar(5'd2, 16'h0040, 8'd7);
        n = 0;
        while (exp_r.size() > 5 && n < 100) begin @(posedge clk); #1; n++; end
        check_eq("t6_midburst", 64'(miso.rvalid), 64'd1);
        arstn = 1'b0;
        #1;
        check_eq("t6_rvalid_drop", 64'(miso.rvalid), 64'd0);
        check_eq("t6_rst_idle", 64'(idle), 64'd1);
        check_eq("t6_rst_counts", 64'({wr_count, rd_count}), 64'd0);
        exp_r.delete(); exp_b.delete(); aw_pend.delete();
        wr_m = 0; rd_m = 0;
        repeat (3) @(posedge clk); #1;
        arstn = 1'b1;
        stray = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            stray = stray | miso.bvalid | miso.rvalid;
        end
        check_eq("t6_no_stale", 64'(stray), 64'd0);
        check_eq("t6_idle_after", 64'(idle), 64'd1);
        check_eq("t6_counts_after", 64'({wr_count, rd_count}), 64'd0);
        send_ar(5'd1, 16'h0004, 8'd0);
        wait_drain("t6_post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_slave_responder.md
Name: axi_slave_responder

Overview:
AXI4 subordinate endpoint that terminates traffic from the NoC's traffic-generating masters.
- Accepts AW/W/AR requests.
- Returns B responses and R bursts with the request's ID after a programmable delay.
- Keeps completion counters for PMU/cosim checking.
- Carries no memory: read data is a deterministic function of ARADDR and the beat index.

Parameters:
DATA_WIDTH, 32, AXI data width
ADDR_WIDTH, 16, AXI address width
ID_W_WIDTH, 5, AWID/BID width
ID_R_WIDTH, 5, ARID/RID width
FIFO_DEPTH, 8, outstanding-request depth of each of the AW, B and AR queues

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
resp_delay_i  in  8  idle cycles inserted before each B response and each R burst
s_axi_i  in  axi_mosi_t  AW/W/AR channels plus BREADY/RREADY from the master
s_axi_o  out  axi_miso_t  AWREADY/WREADY/ARREADY plus B/R channels to the master
wr_count_o  out  16  completed write transactions (B handshakes), wraps at 2^16
rd_count_o  out  16  completed read transactions (RLAST handshakes), wraps at 2^16
idle_o  out  1  all queues empty and all FSMs idle

Behaviour:
- Reset (async, arstn_i low): all FSMs return to IDLE; queues are flushed; counters are cleared.
  - AWREADY, WREADY, ARREADY, BVALID and RVALID = 0, all other outputs = 0, idle_o = 1.
  - Reset mid-burst drops all valids immediately and gives no partial response.
- AW: AWREADY = !aw_q_full. A handshake pushes {AWID, AWLEN}. No pass-through when full.
- AR: ARREADY = !ar_q_full. A handshake pushes {ARID, ARADDR, ARLEN}.
- W FSM:
  - W_IDLE -> W_DATA when the aw_q head is valid and b_q is not full.
  - In W_DATA, WREADY = 1 and beat counter w_cnt counts handshakes.
  - On the handshake where w_cnt == AWLEN: pop aw_q, push {AWID, resp} into b_q, clear w_cnt, return to W_IDLE.
  - WREADY = 0 in W_IDLE, so W beats with no accepted AW stall.
  - resp = OKAY (2'b00) if WLAST was high only on the final beat; otherwise SLVERR (2'b10), and the burst length is still taken from AWLEN.
- B FSM:
  - B_IDLE -> B_DELAY on b_q head valid, loading dly_cnt = resp_delay_i.
  - B_DELAY decrements to 0, then moves to B_SEND (skips B_DELAY when resp_delay_i = 0).
  - B_SEND: BVALID = 1 with BID/BRESP from the head, held stable until BREADY.
  - On the handshake: pop b_q, wr_count_o += 1, go to B_IDLE.
  - Latency: last W handshake at cycle T -> BVALID first high at T+2+resp_delay_i.
- R FSM:
  - R_IDLE -> R_DELAY on ar_q head valid, loading dly_cnt = resp_delay_i.
  - R_DELAY counts down, then moves to R_DATA.
  - R_DATA beat fields:
    - RVALID = 1, RID = head ARID, RRESP = OKAY.
    - RDATA = 'h30 + (ARADDR >> 2) + r_cnt, truncated to DATA_WIDTH.
    - RLAST = (r_cnt == ARLEN).
  - r_cnt increments on each handshake. Payload is held while RREADY = 0.
  - On the RLAST handshake: pop ar_q, rd_count_o += 1, clear r_cnt, go to R_IDLE.
  - Latency: AR handshake at T -> first RVALID at T+2+resp_delay_i.
- Ordering:
  - In-order per channel.
  - Read and write paths are fully independent and may complete in the same cycle.
  - Both counters may increment in the same cycle.
- resp_delay_i is sampled only on leaving B_IDLE/R_IDLE; changes mid-delay are ignored.
- Counter arithmetic: 16-bit modulo, no saturation.
- idle_o = all queues empty and W/B/R FSMs in IDLE.

Decomposition:
- The shared AXI package holds axi_mosi_t/axi_miso_t (via axi_type.svh) and adds RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
- No new sub-module. The block instantiates the existing stream_fifo three times:
  - aw_q: width ID_W_WIDTH+8
  - b_q: width ID_W_WIDTH+2
  - ar_q: width ID_R_WIDTH+ADDR_WIDTH+8
- Queue-full = !stream_fifo.ready_o.

Test Plan:
1. Delay 0, BREADY=1: AW{id=3,len=3} + 4 W beats (WLAST on beat 4) -> BVALID at T+2 with BID=3, BRESP=00; wr_count_o=1.
2. Delay 5: AR{id=7,addr='h8,len=2} -> RVALID at T+7; RDATA 'h32,'h33,'h34; RLAST on beat 3; RID=7; rd_count_o=1.
3. WLAST asserted on beat 2 of len=3 burst -> 4 beats still consumed; BRESP=10.
4. Fill AW queue with 8 AWs while W is held off -> AWREADY=0 on the 9th; it reasserts the cycle after the first burst completes.
5. RREADY toggling every other cycle with len=7 -> RDATA/RID stable while stalled; exactly 8 beats; single RLAST.
6. Assert arstn_i mid-R burst -> RVALID drops immediately; after release idle_o=1, counters=0, no stale responses.
